mips_result_checker: RTL and testbench

MIPS_RESULT_CHECKER -- requirements
Module: mips_result_checker

---
 rtl/mips_result_checker_pkg.sv | 19 +
 rtl/mips_expect_table.sv | 54 +++++
 rtl/mips_result_checker.sv | 165 ++++++++++++++++
 tb/tb_mips_result_checker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_result_checker_pkg.sv
// ----------------------------------------------------------------------------
// mips_result_checker_pkg
// Shared definitions for the MIPS result checker: checker FSM state encoding
// and the default register/data and register-index widths.
// ----------------------------------------------------------------------------
package mips_result_checker_pkg;

   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefAddrWidth = 5;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StArmed = 3'd1,
      StScan  = 3'd2,
      StDrain = 3'd3,
      StDone  = 3'd4
   } chk_state_e;

endpackage

// File: rtl/mips_expect_table.sv
// ----------------------------------------------------------------------------
// mips_expect_table
// Expected-result table: NUM_REGS entries of {check bit, expected value}.
// One synchronous write port, one asynchronous read port. Only the check bits
// are reset; expected values keep whatever was last written.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   i_we/i_waddr/i_wdata/i_wcheck  write port
//   i_raddr                    read index
//   o_rdata/o_rcheck           entry at i_raddr (0 when out of range)
// ----------------------------------------------------------------------------
module mips_expect_table #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_wcheck,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rcheck
);

   logic [DATA_WIDTH-1:0] r_data [NUM_REGS];
   logic [NUM_REGS-1:0]   r_check;
   logic                  w_wr_ok;
   logic                  w_rd_ok;

   // Indices beyond NUM_REGS are dropped on write and read back as unchecked.
   assign w_wr_ok = (32'(i_waddr) < NUM_REGS);
   assign w_rd_ok = (32'(i_raddr) < NUM_REGS);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_check <= '0;
      end else if (i_we && w_wr_ok) begin
         r_check[i_waddr] <= i_wcheck;
      end
   end

   always_ff @(posedge clk) begin
      if (i_we && w_wr_ok) begin
         r_data[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata  = w_rd_ok ? r_data[i_raddr] : '0;
   assign o_rcheck = w_rd_ok ? r_check[i_raddr] : 1'b0;

endmodule

// File: rtl/mips_result_checker.sv
// ----------------------------------------------------------------------------
// mips_result_checker
// Monitors a MIPS run: after i_arm it counts cycles until i_halt or the
// timeout limit, then scans the register file through a debug read port and
// compares each checked register against the expected table.
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   i_arm, i_halt           run start pulse, pipeline halt
//   i_timeout_limit         cycles allowed before a forced check
//   i_exp_*                 expected-table write port
//   o_rf_addr, i_rf_data    register-file debug read (1-cycle latency)
//   o_busy/o_done/o_pass/o_timeout   status
//   o_fail_count, o_first_fail_addr, o_first_fail_got   mismatch report
//   o_cycle_count           cycles from arm to halt/timeout
// ----------------------------------------------------------------------------
module mips_result_checker
   import mips_result_checker_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_arm,
   input  logic                  i_halt,
   input  logic [CNT_WIDTH-1:0]  i_timeout_limit,
   input  logic                  i_exp_we,
   input  logic [ADDR_WIDTH-1:0] i_exp_addr,
   input  logic [DATA_WIDTH-1:0] i_exp_data,
   input  logic                  i_exp_check,
   output logic [ADDR_WIDTH-1:0] o_rf_addr,
   input  logic [DATA_WIDTH-1:0] i_rf_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic                  o_timeout,
   output logic [ADDR_WIDTH:0]   o_fail_count,
   output logic [ADDR_WIDTH-1:0] o_first_fail_addr,
   output logic [DATA_WIDTH-1:0] o_first_fail_got,
   output logic [CNT_WIDTH-1:0]  o_cycle_count
);

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);

   chk_state_e            r_state;
   logic [ADDR_WIDTH-1:0] r_scan_addr;
   logic                  r_cmp_valid;
   logic [ADDR_WIDTH-1:0] r_cmp_addr;
   logic [CNT_WIDTH-1:0]  r_cycle_count;
   logic [ADDR_WIDTH:0]   r_fail_count;
   logic [ADDR_WIDTH-1:0] r_first_fail_addr;
   logic [DATA_WIDTH-1:0] r_first_fail_got;
   logic                  r_done;
   logic                  r_pass;
   logic                  r_timeout;

   logic [DATA_WIDTH-1:0] w_exp_data;
   logic                  w_exp_check;
   logic                  w_mismatch;
   logic [ADDR_WIDTH:0]   w_fail_next;

   // Read the table at compare time, so a write lands for every index whose
   // compare has not happened yet.
   mips_expect_table #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_expect_table (
      .clk      (clk),
      .reset    (reset),
      .i_we     (i_exp_we),
      .i_waddr  (i_exp_addr),
      .i_wdata  (i_exp_data),
      .i_wcheck (i_exp_check),
      .i_raddr  (r_cmp_addr),
      .o_rdata  (w_exp_data),
      .o_rcheck (w_exp_check)
   );

   assign w_mismatch  = r_cmp_valid && w_exp_check && (i_rf_data != w_exp_data);
   assign w_fail_next = w_mismatch ? r_fail_count + (ADDR_WIDTH+1)'(1) : r_fail_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state           <= StIdle;
         r_scan_addr       <= '0;
         r_cmp_valid       <= 1'b0;
         r_cmp_addr        <= '0;
         r_cycle_count     <= '0;
         r_fail_count      <= '0;
         r_first_fail_addr <= '0;
         r_first_fail_got  <= '0;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_timeout         <= 1'b0;
      end else begin
         // Compare pipeline: address issued this cycle, data checked next.
         r_cmp_valid <= (r_state == StScan);
         r_cmp_addr  <= r_scan_addr;

         if (w_mismatch) begin
            r_fail_count <= w_fail_next;
            if (r_fail_count == '0) begin
               r_first_fail_addr <= r_cmp_addr;
               r_first_fail_got  <= i_rf_data;
            end
         end

         case (r_state)
            StIdle, StDone: begin
               if (i_arm) begin
                  r_state           <= StArmed;
                  r_cycle_count     <= '0;
                  r_fail_count      <= '0;
                  r_first_fail_addr <= '0;
                  r_first_fail_got  <= '0;
                  r_done            <= 1'b0;
                  r_pass            <= 1'b0;
                  r_timeout         <= 1'b0;
               end
            end
            StArmed: begin
               // Halt wins over a coinciding timeout.
               if (i_halt) begin
                  r_state <= StScan;
               end else if (r_cycle_count == i_timeout_limit) begin
                  r_timeout <= 1'b1;
                  r_state   <= StScan;
               end else if (r_cycle_count != '1) begin
                  r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
               end
            end
            StScan: begin
               if (r_scan_addr == LastAddr) begin
                  r_scan_addr <= '0;
                  r_state     <= StDrain;
               end else begin
                  r_scan_addr <= r_scan_addr + ADDR_WIDTH'(1);
               end
            end
            StDrain: begin
               // Last compare completes this cycle, so include it in pass.
               r_state <= StDone;
               r_done  <= 1'b1;
               r_pass  <= (w_fail_next == '0) && !r_timeout;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_busy            = (r_state == StArmed) || (r_state == StScan) ||
                              (r_state == StDrain);
   assign o_rf_addr         = r_scan_addr;
   assign o_done            = r_done;
   assign o_pass            = r_pass;
   assign o_timeout         = r_timeout;
   assign o_fail_count      = r_fail_count;
   assign o_first_fail_addr = r_first_fail_addr;
   assign o_first_fail_got  = r_first_fail_got;
   assign o_cycle_count     = r_cycle_count;

endmodule

// File: tb/tb_mips_result_checker.sv
module tb_mips_result_checker;

   typedef struct {
      logic [15:0] cyc;
      logic        tmo;
      logic [5:0]  fails;
      logic [4:0]  faddr;
      logic [31:0] fgot;
      logic        pass;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // Default-size instance
   logic        arm = 0, halt = 0, we = 0, wchk = 0;
   logic [15:0] limit = 16'd1000;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data = '0;
   logic        busy, done, pass, tmo;
   logic [5:0]  fail_count;
   logic [4:0]  ffa;
   logic [31:0] ffg;
   logic [15:0] cyc;

   mips_result_checker dut (
      .clk (clk), .reset (reset), .i_arm (arm), .i_halt (halt),
      .i_timeout_limit (limit), .i_exp_we (we), .i_exp_addr (waddr),
      .i_exp_data (wdata), .i_exp_check (wchk), .o_rf_addr (rf_addr),
      .i_rf_data (rf_data), .o_busy (busy), .o_done (done), .o_pass (pass),
      .o_timeout (tmo), .o_fail_count (fail_count), .o_first_fail_addr (ffa),
      .o_first_fail_got (ffg), .o_cycle_count (cyc)
   );

   // Small instance: 8 registers
   logic        s_arm = 0, s_halt = 0, s_we = 0, s_wchk = 0;
   logic [15:0] s_limit = 16'd1000;
   logic [2:0]  s_waddr = '0;
   logic [31:0] s_wdata = '0;
   logic [2:0]  s_rf_addr;
   logic [31:0] s_rf_data = '0;
   logic        s_busy, s_done, s_pass, s_tmo;
   logic [3:0]  s_fail_count;
   logic [2:0]  s_ffa;
   logic [31:0] s_ffg;
   logic [15:0] s_cyc;

   mips_result_checker #(
      .DATA_WIDTH (32), .NUM_REGS (8), .ADDR_WIDTH (3), .CNT_WIDTH (16)
   ) dut_s (
      .clk (clk), .reset (reset), .i_arm (s_arm), .i_halt (s_halt),
      .i_timeout_limit (s_limit), .i_exp_we (s_we), .i_exp_addr (s_waddr),
      .i_exp_data (s_wdata), .i_exp_check (s_wchk), .o_rf_addr (s_rf_addr),
      .i_rf_data (s_rf_data), .o_busy (s_busy), .o_done (s_done), .o_pass (s_pass),
      .o_timeout (s_tmo), .o_fail_count (s_fail_count), .o_first_fail_addr (s_ffa),
      .o_first_fail_got (s_ffg), .o_cycle_count (s_cyc)
   );

   // Register-file models with one-cycle read latency
   logic [31:0] rf_mem [32];
   logic [31:0] rf_mem_s [8];
   always @(posedge clk) rf_data <= rf_mem[rf_addr];
   always @(posedge clk) s_rf_data <= rf_mem_s[s_rf_addr];

   // Reference copy of the expected table
   logic [31:0] exp_val [32];
   bit          exp_chk [32];

   int   n_checks = 0;
   int   n_fail = 0;
   int   done_events = 0;
   exp_t exp_q [$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Outcome of a run from the rules: halt at count h unless the limit is
   // reached first; a coinciding halt wins.
   function automatic exp_t model(input int h, input int lim);
      exp_t r;
      r.tmo   = (lim < h);
      r.cyc   = r.tmo ? 16'(lim) : 16'(h);
      r.fails = '0;
      r.faddr = '0;
      r.fgot  = '0;
      for (int i = 0; i < 32; i++) begin
         if (exp_chk[i] && rf_mem[i] != exp_val[i]) begin
            if (r.fails == 0) begin
               r.faddr = 5'(i);
               r.fgot  = rf_mem[i];
            end
            r.fails++;
         end
      end
      r.pass = (r.fails == 0) && !r.tmo;
      return r;
   endfunction

   // Scoreboard monitor: pops one expectation per rising o_done.
   initial begin
      logic prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset && done && !prev_done) begin
            done_events++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
               e = exp_q.pop_front();
               chk("cycle_count", 64'(cyc), 64'(e.cyc));
               chk("timeout", 64'(tmo), 64'(e.tmo));
               chk("fail_count", 64'(fail_count), 64'(e.fails));
               chk("first_fail_addr", 64'(ffa), 64'(e.faddr));
               chk("first_fail_got", 64'(ffg), 64'(e.fgot));
               chk("pass", 64'(pass), 64'(e.pass));
               chk("busy_at_done", 64'(busy), 64'd0);
               chk("rf_addr_at_done", 64'(rf_addr), 64'd0);
            end
         end
         prev_done = done;
      end
   end

   task automatic write_all();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         we = 1'b1;
         waddr = 5'(i);
         wdata = exp_val[i];
         wchk = exp_chk[i];
      end
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic clear_tables();
      for (int i = 0; i < 32; i++) begin
         exp_val[i] = '0;
         exp_chk[i] = 1'b0;
         rf_mem[i] = $urandom;
      end
   endtask

   task automatic run(input int h, input int lim, input bit xarm);
      int n;
      exp_q.push_back(model(h, lim));
      @(negedge clk);
      limit = 16'(lim);
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      for (int i = 0; i < h; i++) begin
         @(negedge clk);
         arm = xarm && (i == 1);
      end
      arm = 1'b0;
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_wait", 64'(done), 64'd1);
      @(negedge clk);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) rf_mem_s[i] = 32'(i);
      clear_tables();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_timeout", 64'(tmo), 64'd0);
      chk("rst_fail_count", 64'(fail_count), 64'd0);
      chk("rst_cycle_count", 64'(cyc), 64'd0);
      chk("rst_rf_addr", 64'(rf_addr), 64'd0);
      reset = 1'b1;

      // Matching run, halt at 40; extra arm pulse mid-run must be ignored
      rf_mem[3] = 32'd0;
      rf_mem[4] = 32'd30;
      rf_mem[6] = 32'hFFFF_FFE1;
      exp_val[3] = 32'd0;         exp_chk[3] = 1'b1;
      exp_val[4] = 32'd30;        exp_chk[4] = 1'b1;
      exp_val[6] = 32'hFFFF_FFE1; exp_chk[6] = 1'b1;
      write_all();
      run(40, 1000, 1'b1);

      // Two mismatches; lowest index is reported
      rf_mem[4] = 32'd31;
      rf_mem[6] = 32'd0;
      run(40, 1000, 1'b0);

      // Timeout at 100 with matching register file
      rf_mem[4] = 32'd30;
      rf_mem[6] = 32'hFFFF_FFE1;
      run(200, 100, 1'b0);

      // Halt coincides with limit
      run(50, 50, 1'b0);

      // Randomized runs
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 32; i++) begin
            rf_mem[i] = $urandom;
            exp_val[i] = ($urandom_range(0, 3) == 0) ? $urandom : rf_mem[i];
            exp_chk[i] = ($urandom_range(0, 1) == 1);
         end
         write_all();
         run(int'($urandom_range(0, 70)), int'($urandom_range(0, 60)), 1'b0);
      end

      // Reset in the middle of the scan, at index 10
      for (int i = 0; i < 32; i++) exp_chk[i] = 1'b1;
      write_all();
      n = done_events;
      @(negedge clk);
      limit = 16'd1000;
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      repeat (5) @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      repeat (10) @(negedge clk);
      chk("scan_index_10", 64'(rf_addr), 64'd10);
      chk("scan_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      arm = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 32; i++) exp_chk[i] = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rf_addr", 64'(rf_addr), 64'd0);
      chk("abort_cycle_count", 64'(cyc), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      repeat (3) @(negedge clk);
      chk("arm_in_reset_ignored", 64'(busy), 64'd0);
      reset = 1'b1;
      arm = 1'b0;
      repeat (40) @(negedge clk);
      chk("no_done_after_abort", 64'(done_events - n), 64'd0);
      chk("still_idle", 64'(busy), 64'd0);

      // Check bits cleared by reset: run passes with any register contents
      for (int i = 0; i < 32; i++) rf_mem[i] = ~exp_val[i];
      run(7, 1000, 1'b0);

      // Small instance: only indices 0..7, done NUM_REGS+2 edges after halt
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         s_we = 1'b1;
         s_waddr = 3'(i);
         s_wdata = (i == 7) ? 32'd5 : 32'hDEAD_0000;
         s_wchk = (i == 7) || (i == 0);
         if (i == 0) s_wdata = 32'd0;
         @(negedge clk);
      end
      s_we = 1'b0;
      rf_mem_s[7] = 32'd6;
      s_arm = 1'b1;
      @(negedge clk);
      s_arm = 1'b0;
      repeat (3) @(negedge clk);
      s_halt = 1'b1;
      n = 0;
      while (!s_done && n < 50) begin
         @(posedge clk);
         #1;
         s_halt = 1'b0;
         n++;
      end
      chk("small_done_latency", 64'(n), 64'd10);
      chk("small_cycle_count", 64'(s_cyc), 64'd3);
      chk("small_fail_count", 64'(s_fail_count), 64'd1);
      chk("small_first_fail_addr", 64'(s_ffa), 64'd7);
      chk("small_first_fail_got", 64'(s_ffg), 64'd6);
      chk("small_pass", 64'(s_pass), 64'd0);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
